ifid_pipe_reg: RTL and testbench
================================

Name: ifid_pipe_reg

Overview:
Parametrised successor of the fixed IF/ID pipeline register for the scpu datapath. Carries PC and instruction from fetch to decode with a valid/ready handshake, a one-entry skid buffer for registered backpressure, synchronous flush for branch/jump redirect, and NOP bubble insertion. Sits between the IF stage (PC/IMEM) and the ID stage (decoder/regfile read).

Parameters:
XLEN, 32, width of PC and instruction words
NOP_INST, 32'h00000013, instruction presented when no valid entry (addi x0,x0,0)
RESET_PC, 32'h00000000, PC value held in output register after reset
CNT_W, 16, width of optional performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
in_valid  in  1  IF offers an instruction
in_ready  out  1  register can accept (registered, no comb path from out_ready)
in_pc  in  XLEN  PC of offered instruction
in_inst  in  XLEN  offered instruction
flush  in  1  synchronous kill of all held entries (redirect from EX)
out_valid  out  1  ID-side entry valid
out_ready  in  1  ID consumes entry
out_pc  out  XLEN  PC of held entry
out_inst  out  XLEN  held instruction; NOP_INST when out_valid=0
perf_stall_cnt  out  CNT_W  stall-cycle count (feature-dependent)
perf_bubble_cnt  out  CNT_W  bubble-cycle count (feature-dependent)

Behaviour:
- State: main entry M (m_valid, m_pc, m_inst), skid entry S (s_valid, s_pc, s_inst).
- Reset (rst=0, async): m_valid=0, s_valid=0, m_pc=RESET_PC, m_inst=NOP_INST, in_ready=1, out_valid=0, out_pc=RESET_PC, out_inst=NOP_INST, counters 0.
- out_valid=m_valid; out_pc=m_pc; out_inst = m_valid ? m_inst : NOP_INST.
- in_ready = ~s_valid (flop-derived only).
- accept = in_valid & in_ready; drain = ~m_valid | out_ready.
- Priority per clock edge: flush > normal update.
- flush=1: m_valid<=0, s_valid<=0, m_inst<=NOP_INST, m_pc unchanged; same-cycle input dropped even if accept; next cycle in_ready=1, out_valid=0.
- Normal, s_valid=1: if drain, M<=S, s_valid<=0; else hold both. No accept possible (in_ready=0).
- Normal, s_valid=0: accept & drain -> M<=input, m_valid<=1. accept & ~drain -> S<=input, s_valid<=1, M held. ~accept & drain -> m_valid<=0 (m_inst<=NOP_INST). ~accept & ~drain -> hold.
- Latency: accept to out_valid = 1 cycle; sustained throughput 1/cycle with out_ready=1.
- Order preserved: S never overtakes M; at most 2 entries held.
- Data regs of an invalid entry are don't-care except m_inst, which is NOP_INST after reset/flush/drain-empty.
- Reset mid-operation: all entries lost immediately, outputs to reset values regardless of clk.
- out_valid=1 & out_ready=0: out_pc/out_inst stable until consumed.

Optional Feature:
Macro IFID_PIPE_REG_PERF_EN.
- Defined: perf_stall_cnt increments every cycle with out_valid & ~out_ready; perf_bubble_cnt increments every cycle with ~out_valid; both saturate at all-ones, clear on reset only (not on flush).
- Undefined: both ports tied to 0, no counter flops.

Decomposition:
- Shared package scpu_pkg: XLEN default, NOP_INST constant, RESET_PC constant, ifid_entry struct typedef {pc, inst}.
- Natural sub-module: sat_counter (CNT_W, inc, count), instantiated twice under the macro.

Test Plan:
- Reset: rst=0 mid-run with 2 entries held -> out_valid=0, out_inst=32'h00000013, out_pc=0, in_ready=1 immediately.
- Streaming: out_ready=1, in_valid=1 with PCs 0,4,8,C -> out_pc 0,4,8,C on consecutive cycles, one cycle after each accept, in_ready stays 1.
- Backpressure: out_ready=0 after PC 0x10 held, send 0x14 -> in_ready=0 next cycle; raise out_ready -> out 0x10 then 0x14, no loss or duplication.
- Flush: with 0x20 in M and 0x24 in S, flush=1 plus in_valid=1 (0x28) -> next cycle out_valid=0, out_inst=NOP, in_ready=1; 0x28 never appears.
- Bubble: in_valid=0 for 3 cycles, out_ready=1 -> out_valid=0, out_inst=32'h00000013 each cycle.
- Perf (macro defined): 5 stall cycles, 3 bubble cycles -> perf_stall_cnt=5, perf_bubble_cnt=3; CNT_W=4 with 20 stall cycles -> saturates at 15.

Source files
------------

// File: rtl/scpu_pkg.sv
// Shared scpu datapath constants and the IF/ID entry type.
package scpu_pkg;

   localparam int XLEN_DEF = 32;
   localparam logic [XLEN_DEF-1:0] NOP_INST_C = 32'h0000_0013;
   localparam logic [XLEN_DEF-1:0] RESET_PC_C = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN_DEF-1:0] pc;
      logic [XLEN_DEF-1:0] inst;
   } ifid_entry_t;

endpackage

// File: rtl/ifid_pipe_reg_sat_counter.sv
// Saturating up-counter used for the IF/ID performance counters.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/ifid_pipe_reg.sv
// IF/ID pipeline register: valid/ready handshake, one-entry skid buffer, flush, NOP bubbles.
// Optional stall/bubble counters are built when IFID_PIPE_REG_PERF_EN is defined.
module ifid_pipe_reg
   import scpu_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] NOP_INST = XLEN'(NOP_INST_C),
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_C),
   parameter int              CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_inst,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_inst,
   output logic [CNT_W-1:0] perf_stall_cnt,
   output logic [CNT_W-1:0] perf_bubble_cnt
);

   logic            m_valid;
   logic [XLEN-1:0] m_pc;
   logic [XLEN-1:0] m_inst;
   logic            s_valid;
   logic [XLEN-1:0] s_pc;
   logic [XLEN-1:0] s_inst;
   logic            accept;
   logic            drain;
   logic            skid_load;

   // in_ready depends only on the skid flop, so ID backpressure never reaches IF combinationally.
   assign in_ready  = ~s_valid;
   assign accept    = in_valid & in_ready;
   assign drain     = ~m_valid | out_ready;
   assign skid_load = ~flush & ~s_valid & accept & ~drain;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_pc    <= RESET_PC;
         m_inst  <= NOP_INST;
      end else if (flush) begin
         m_valid <= 1'b0;
         s_valid <= 1'b0;
         m_inst  <= NOP_INST;
      end else if (s_valid) begin
         if (drain) begin
            m_valid <= 1'b1;
            m_pc    <= s_pc;
            m_inst  <= s_inst;
            s_valid <= 1'b0;
         end
      end else if (accept) begin
         if (drain) begin
            m_valid <= 1'b1;
            m_pc    <= in_pc;
            m_inst  <= in_inst;
         end else begin
            s_valid <= 1'b1;
         end
      end else if (drain) begin
         m_valid <= 1'b0;
         m_inst  <= NOP_INST;
      end
   end

   // Skid data is meaningless while s_valid=0, so it needs no reset.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         s_pc   <= in_pc;
         s_inst <= in_inst;
      end
   end

   assign out_valid = m_valid;
   assign out_pc    = m_pc;
   assign out_inst  = m_valid ? m_inst : NOP_INST;

`ifdef IFID_PIPE_REG_PERF_EN
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (m_valid & ~out_ready),
      .count (perf_stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (~m_valid),
      .count (perf_bubble_cnt)
   );
`else
   assign perf_stall_cnt  = '0;
   assign perf_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_ifid_pipe_reg.sv
// Scoreboard bench for ifid_pipe_reg: directed stimulus pushes expected entries, a monitor pops on handshake.
module tb_ifid_pipe_reg;
   import scpu_pkg::*;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_inst = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic [15:0] perf_stall_cnt;
   logic [15:0] perf_bubble_cnt;

   int checks = 0;
   int errors = 0;
   ifid_entry_t exp_q[$];

   always #5 clk = ~clk;

   ifid_pipe_reg u_dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_pc           (in_pc),
      .in_inst         (in_inst),
      .flush           (flush),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_pc          (out_pc),
      .out_inst        (out_inst),
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_bubble_cnt (perf_bubble_cnt)
   );

`ifdef IFID_PIPE_REG_PERF_EN
   logic        in_ready4;
   logic        out_valid4;
   logic [31:0] out_pc4;
   logic [31:0] out_inst4;
   logic [3:0]  stall4;
   logic [3:0]  bubble4;

   // Permanently stalled narrow-counter instance for saturation.
   ifid_pipe_reg #(.CNT_W(4)) u_dut4 (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (1'b1),
      .in_ready        (in_ready4),
      .in_pc           (32'h0000_0100),
      .in_inst         (32'h0010_0093),
      .flush           (1'b0),
      .out_valid       (out_valid4),
      .out_ready       (1'b0),
      .out_pc          (out_pc4),
      .out_inst        (out_inst4),
      .perf_stall_cnt  (stall4),
      .perf_bubble_cnt (bubble4)
   );
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] inst);
      ifid_entry_t e;
      in_valid = 1'b1;
      in_pc    = pc;
      in_inst  = inst;
      e.pc     = pc;
      e.inst   = inst;
      exp_q.push_back(e);
   endtask

   // Monitor: every consumed entry must match the oldest expected one.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_out_pc", out_pc, 32'hxxxx_xxxx);
         end else begin
            ifid_entry_t e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_inst", out_inst, e.inst);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog_timeout actual=%0t expected=finish", $time);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) cycle();
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_out_inst", out_inst, NOP);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      rst = 1'b1;

      // Streaming at full rate
      out_ready = 1'b1;
      send(32'h00, 32'h0010_0093);
      check("stream_in_ready", {31'b0, in_ready}, 32'd1);
      cycle();
      check("stream_lat_valid", {31'b0, out_valid}, 32'd1);
      check("stream_lat_pc", out_pc, 32'h00);
      send(32'h04, 32'h0020_0113);
      cycle();
      check("stream_pc4", out_pc, 32'h04);
      send(32'h08, 32'h0030_0193);
      cycle();
      check("stream_pc8", out_pc, 32'h08);
      send(32'h0C, 32'h0040_0213);
      check("stream_in_ready_last", {31'b0, in_ready}, 32'd1);
      cycle();
      check("stream_pcC", out_pc, 32'h0C);
      in_valid = 1'b0;

      // Bubbles
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bubble_valid", {31'b0, out_valid}, 32'd0);
         check("bubble_inst", out_inst, NOP);
      end

      // Backpressure into the skid entry
      out_ready = 1'b0;
      send(32'h10, 32'h0050_0293);
      cycle();
      check("bp_in_ready_m", {31'b0, in_ready}, 32'd1);
      check("bp_pc10", out_pc, 32'h10);
      send(32'h14, 32'h0060_0313);
      cycle();
      in_valid = 1'b0;
      check("bp_in_ready_full", {31'b0, in_ready}, 32'd0);
      check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      check("bp_hold_pc", out_pc, 32'h10);
      cycle();
      check("bp_stable_pc", out_pc, 32'h10);
      check("bp_stable_inst", out_inst, 32'h0050_0293);
      out_ready = 1'b1;
      cycle();
      check("bp_drain_pc14", out_pc, 32'h14);
      check("bp_drain_in_ready", {31'b0, in_ready}, 32'd1);
      cycle();
      check("bp_empty", {31'b0, out_valid}, 32'd0);

      // Flush with both entries held; same-cycle input dropped
      out_ready = 1'b0;
      send(32'h20, 32'h0070_0393);
      cycle();
      send(32'h24, 32'h0080_0413);
      cycle();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_pc    = 32'h28;
      in_inst  = 32'h0090_0493;
      exp_q.delete();
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_valid", {31'b0, out_valid}, 32'd0);
      check("flush_inst", out_inst, NOP);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("flush_no_28", {31'b0, out_valid}, 32'd0);
      end

      // Flush while an accept is happening
      out_ready = 1'b0;
      send(32'h50, 32'h00a0_0513);
      cycle();
      flush    = 1'b1;
      in_valid = 1'b1;
      in_pc    = 32'h54;
      in_inst  = 32'h00b0_0593;
      exp_q.delete();
      cycle();
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush2_valid", {31'b0, out_valid}, 32'd0);
      check("flush2_in_ready", {31'b0, in_ready}, 32'd1);
      cycle();
      check("flush2_no_54", {31'b0, out_valid}, 32'd0);

      // Asynchronous reset with two entries held
      send(32'h30, 32'h00c0_0613);
      cycle();
      send(32'h34, 32'h00d0_0693);
      cycle();
      in_valid = 1'b0;
      check("pre_rst_in_ready", {31'b0, in_ready}, 32'd0);
      #2;
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("arst_out_valid", {31'b0, out_valid}, 32'd0);
      check("arst_out_inst", out_inst, NOP);
      check("arst_out_pc", out_pc, 32'd0);
      check("arst_in_ready", {31'b0, in_ready}, 32'd1);
      cycle();
      rst = 1'b1;

      // Counters: 1 bubble, 5 stalls, then 2 more bubbles
      out_ready = 1'b0;
      send(32'h40, 32'h00e0_0713);
      cycle();
      in_valid = 1'b0;
      repeat (5) cycle();
`ifdef IFID_PIPE_REG_PERF_EN
      check("perf_stall5", {16'b0, perf_stall_cnt}, 32'd5);
      check("perf_bubble1", {16'b0, perf_bubble_cnt}, 32'd1);
`else
      check("perf_stall_off", {16'b0, perf_stall_cnt}, 32'd0);
      check("perf_bubble_off", {16'b0, perf_bubble_cnt}, 32'd0);
`endif
      out_ready = 1'b1;
      repeat (3) cycle();
`ifdef IFID_PIPE_REG_PERF_EN
      check("perf_stall_final", {16'b0, perf_stall_cnt}, 32'd5);
      check("perf_bubble3", {16'b0, perf_bubble_cnt}, 32'd3);
      repeat (20) cycle();
      check("perf_sat_stall", {28'b0, stall4}, 32'd15);
      check("perf_sat_bubble", {28'b0, bubble4}, 32'd1);
`else
      check("perf_stall_off2", {16'b0, perf_stall_cnt}, 32'd0);
      check("perf_bubble_off2", {16'b0, perf_bubble_cnt}, 32'd0);
`endif

      cycle();
      check("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
